// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit: PC sequencing, memory fetch handshake, instruction register
//
// Purpose:
//   Three-state fetch/execute sequencer (IDLE -> FETCH -> EXEC -> FETCH ...).
//   FETCH requests the word at pc and waits for imem_ready. EXEC presents the
//   captured instruction and, once stall is low, advances pc to the
//   sequential, branch or jump target.
//
// Optional feature:
//   FETCH_TIMEOUT_EN - when defined, adds a 4-bit wait counter. After 16
//   consecutive FETCH cycles with imem_ready low, the sticky fetch_err flag
//   is set. When undefined, fetch_err is tied to 0.
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous active-high reset
//   imem_req    out  1   instruction memory read request (FETCH only)
//   imem_addr   out  32  byte address of the requested word (= pc)
//   imem_ready  in   1   imem_rdata valid this cycle
//   imem_rdata  in   32  fetched instruction word
//   jump        in   1   jump taken
//   branch      in   1   current instruction is beq
//   alu_zero    in   1   ALU zero flag for beq
//   stall       in   1   hold the current instruction in EXEC
//   instr       out  32  captured instruction register
//   opcode      out  6   instr[31:26]
//   instr_valid out  1   instr is valid for execution
//   pc          out  32  address of instr
//   fetch_err   out  1   sticky fetch-timeout flag

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        jump,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        stall,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_off;
    logic [31:0] jump_target;
    logic [31:0] next_pc;

    // ------------------------------------------------------------------
    // Next-PC computation (all arithmetic wraps modulo 2^32)
    // ------------------------------------------------------------------
    assign pc_plus4    = pc_q + 32'd4;
    // Word offset: sign-extended 16-bit immediate shifted left by two.
    assign branch_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    // Jump keeps the 256 MB region of the sequential address.
    assign jump_target = {pc_plus4[31:28], instr_q[25:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && alu_zero) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = S_EXEC;
                end
            end
            S_EXEC: begin
                // While stalled everything holds, including control inputs.
                if (!stall) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    state_d       = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Fetch timeout watchdog
    // ------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       fetch_err_q, fetch_err_d;

    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        fetch_err_d = fetch_err_q;
        if (state_q == S_FETCH && !imem_ready) begin
            // 16th consecutive wait: flag and restart the count; the
            // request itself keeps going unchanged.
            if (wait_cnt_q == 4'hF) begin
                fetch_err_d = 1'b1;
                wait_cnt_d  = 4'h0;
            end else begin
                wait_cnt_d  = wait_cnt_q + 4'h1;
            end
        end else begin
            wait_cnt_d = 4'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q  <= 4'h0;
            fetch_err_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign fetch_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Request decoded from the state register so reset drops it at once.
    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        jump;
    logic        branch;
    logic        alu_zero;
    logic        stall;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .jump        (jump),
        .branch      (branch),
        .alu_zero    (alu_zero),
        .stall       (stall),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] word;
        logic        j;
        logic        b;
        logic        z;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Precondition: just after a negedge with the DUT in FETCH.
    // Returns just after the negedge where the DUT is in FETCH again.
    task automatic fetch_exec(input logic [31:0] word, input logic j, input logic b, input logic z);
        imem_ready = 1'b1;
        imem_rdata = word;
        jump       = j;
        branch     = b;
        alu_zero   = z;
        @(negedge clk);
        chk("exec_valid", {31'd0, instr_valid}, 32'd1);
        imem_ready = 1'b0;
        @(negedge clk);
        jump     = 1'b0;
        branch   = 1'b0;
        alu_zero = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_err;

        vecs[0] = '{32'h0000_0040, 32'h0800_0010, 1'b1, 1'b0, 1'b0, 32'h0000_0040};
        vecs[1] = '{32'h0000_0040, 32'h0800_0010, 1'b1, 1'b1, 1'b1, 32'h0000_0040};
        vecs[2] = '{32'h0000_0100, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'h0000_00FC};
        vecs[3] = '{32'h0000_0100, 32'h1000_FFFE, 1'b0, 1'b1, 1'b0, 32'h0000_0104};
        vecs[4] = '{32'h0000_0200, 32'h1000_0003, 1'b0, 1'b1, 1'b1, 32'h0000_0210};
        vecs[5] = '{32'h0000_0200, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 32'h0000_0204};
        vecs[6] = '{32'h0000_0000, 32'h1000_FFFE, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC};

        rst        = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h0;
        jump       = 1'b0;
        branch     = 1'b0;
        alu_zero   = 1'b0;
        stall      = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_req",   {31'd0, imem_req},    32'd0);
        chk("rst_pc",    pc,                   32'h0);
        chk("rst_instr", instr,                32'h0);
        chk("rst_opc",   {26'd0, opcode},      32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_err",   {31'd0, fetch_err},   32'd0);
        rst = 1'b0;

        // Free-running sequential fetch with ready tied high
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("seq_addr",  imem_addr,             32'(k / 2) * 32'd4);
            chk("seq_req",   {31'd0, imem_req},     32'((k % 2) == 0));
            chk("seq_valid", {31'd0, instr_valid},  32'((k % 2) == 1));
        end
        imem_ready = 1'b0;
        @(negedge clk);
        chk("seq_addr_next", imem_addr, 32'h10);

        // Table-driven next-pc vectors
        for (int v = 0; v < 7; v++) begin
            fetch_exec({6'h02, vecs[v].start_pc[27:2]}, 1'b1, 1'b0, 1'b0);
            chk("vec_start", imem_addr, vecs[v].start_pc);
            fetch_exec(vecs[v].word, vecs[v].j, vecs[v].b, vecs[v].z);
            chk("vec_addr",  imem_addr,          vecs[v].exp_pc);
            chk("vec_pc",    pc,                 vecs[v].exp_pc);
            chk("vec_req",   {31'd0, imem_req},  32'd1);
            chk("vec_instr", instr,              vecs[v].word);
            chk("vec_opc",   {26'd0, opcode},    {26'd0, vecs[v].word[31:26]});
        end

        // Wrap from 0xFFFF_FFFC to 0
        fetch_exec(32'h0, 1'b0, 1'b0, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Stall for three EXEC cycles; late rdata and jump must be ignored
        stall      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hAC11_2233;
        jump       = 1'b1;
        @(negedge clk);
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            chk("stall_instr", instr,                32'hAC11_2233);
            chk("stall_pc",    pc,                   32'h0);
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_req",   {31'd0, imem_req},    32'd0);
            @(negedge clk);
        end
        stall      = 1'b0;
        jump       = 1'b0;
        imem_ready = 1'b0;
        @(negedge clk);
        chk("unstall_pc",    pc,                   32'h4);
        chk("unstall_valid", {31'd0, instr_valid}, 32'd0);
        chk("unstall_instr", instr,                32'hAC11_2233);

        // Long wait in FETCH
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
            exp_err = (i >= 16);
`else
            exp_err = 1'b0;
`endif
            chk("wait_addr", imem_addr,          32'h4);
            chk("wait_req",  {31'd0, imem_req},  32'd1);
            chk("wait_err",  {31'd0, fetch_err}, {31'd0, exp_err});
        end

        // Asynchronous reset in the middle of the wait
        #2 rst = 1'b1;
        #1;
        chk("arst_req", {31'd0, imem_req},  32'd0);
        chk("arst_pc",  pc,                 32'h0);
        chk("arst_err", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("refetch_req",  {31'd0, imem_req}, 32'd1);
        chk("refetch_addr", imem_addr,         32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  byte address of requested word; equals pc.
REQ-006 SHALL have port imem_ready  input  1  memory has imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port jump  input  1  from control unit; jump taken.
REQ-009 SHALL have port branch  input  1  from control unit; instruction is beq.
REQ-010 SHALL have port alu_zero  input  1  ALU zero flag for beq.
REQ-011 SHALL have port stall  input  1  hold current instruction; do not advance PC.
REQ-012 SHALL have port instr  output  32  captured instruction register.
REQ-013 SHALL have port opcode  output  6  instr[31:26], feeds control unit.
REQ-014 SHALL have port instr_valid  output  1  instr holds a valid instruction for execution.
REQ-015 SHALL have port pc  output  32  address of instr.
REQ-016 SHALL have port fetch_err  output  1  sticky fetch-timeout flag.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, FETCH, EXEC.
REQ-018 IDLE SHALL transition unconditionally to FETCH on the next edge.
REQ-019 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ready=1.
REQ-020 On an edge in FETCH with imem_ready=1: instr <= imem_rdata, instr_valid <= 1, state <= EXEC; imem_ready combinationally asserted in the request cycle is legal.
REQ-021 In IDLE and EXEC, imem_req SHALL be 0.
REQ-022 In EXEC with stall=1, state, pc and instr SHALL hold; branch/jump ignored.
REQ-023 On an edge in EXEC with stall=0: pc <= next_pc, instr_valid <= 0, state <= FETCH.
REQ-024 next_pc priority: jump=1 -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch&alu_zero -> pc_plus4 + (sign-extended instr[15:0] << 2); else pc_plus4.
REQ-025 pc_plus4 = pc + 4, all PC arithmetic modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-026 jump and branch both 1 SHALL select the jump target.
REQ-027 opcode SHALL be combinationally instr[31:26] at all times.
REQ-028 Minimum instruction period SHALL be 2 cycles (one FETCH with immediate ready, one EXEC).
REQ-029 imem_rdata arriving with imem_ready=1 outside FETCH SHALL be ignored.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, timeout counter=0.
REQ-031 rst asserted mid-fetch SHALL drop imem_req immediately; the pending response SHALL be discarded.
REQ-032 First FETCH after reset release SHALL occur one cycle later (IDLE->FETCH) at RESET_PC.

Configuration
REQ-033 Macro FETCH_TIMEOUT_EN SHALL compile in a 4-bit wait counter.
REQ-034 With FETCH_TIMEOUT_EN: counter increments each FETCH cycle with imem_ready=0, clears on leaving FETCH; on the 16th consecutive wait cycle fetch_err <= 1 (sticky until reset), counter clears, request continues unchanged.
REQ-035 Without FETCH_TIMEOUT_EN: no counter; fetch_err SHALL be constant 0.

Verification
REQ-036 Reset, imem_ready tied 1, stall=0, no branch/jump -> imem_addr sequence 0,4,8,C; instr_valid high every second cycle.
REQ-037 instr=32'h0800_0010 in EXEC at pc=0x40, jump=1 -> next imem_addr=0x0000_0040; with jump=1 and branch=1, alu_zero=1 same target.
REQ-038 beq at pc=0x100, instr[15:0]=16'hFFFE, branch=1, alu_zero=1 -> next pc 0x0FC; alu_zero=0 -> 0x104.
REQ-039 stall=1 for 3 EXEC cycles -> instr, pc, instr_valid=1 unchanged, imem_req=0; advance on first stall=0 edge.
REQ-040 imem_ready held 0 for 20 cycles -> imem_addr stable; fetch_err=1 after cycle 16 with FETCH_TIMEOUT_EN, 0 without; rst mid-wait -> imem_req=0 and pc=RESET_PC immediately.
